z80_idx_exec: RTL and testbench

Z80_IDX_EXEC -- requirements
Module: z80_idx_exec

---
 rtl/z80_idx_exec.sv | 189 ++++++++++++++++++
 tb/tb_z80_idx_exec.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_idx_exec.sv
// z80_idx_exec: executes one Z80 indexed instruction, either LD (IX/IY+d),n or
// LD r,(IX/IY+d). It fetches the instruction bytes over a simple req/ack bus,
// performs the data access, and then emits a one-cycle retirement record.
// Ports: clk/reset_n; start with ip_in/ix_in/iy_in; busy; mem_* bus master;
//        reg_* 8-bit register write; z80fi_* retirement record; error pulse.
module z80_idx_exec #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] ip_in,
  input  logic [15:0] ix_in,
  input  logic [15:0] iy_in,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        reg_we,
  output logic [2:0]  reg_sel,
  output logic [7:0]  reg_wdata,
  output logic        z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [2:0]  z80fi_insn_len,
  output logic [15:0] z80fi_reg_ip_in,
  output logic [15:0] z80fi_reg_ip_out,
  output logic [15:0] z80fi_reg_ix_in,
  output logic [15:0] z80fi_reg_iy_in,
  output logic        z80fi_mem_wr,
  output logic        z80fi_mem_rd,
  output logic [15:0] z80fi_mem_waddr,
  output logic [15:0] z80fi_mem_raddr,
  output logic [7:0]  z80fi_mem_wdata,
  output logic [7:0]  z80fi_mem_rdata,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, F_PFX, F_OP, F_D, F_N, MEM_WR, MEM_RD, RETIRE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ip;
  logic [15:0] r_ix;
  logic [15:0] r_iy;
  logic [31:0] r_insn;
  logic [7:0]  r_rdata;
  logic [31:0] r_wait;
  logic        r_error;

  logic        w_err;
  logic        w_req;
  logic [15:0] w_addr;
  logic [15:0] w_base;
  logic [15:0] w_ea;
  logic        w_is_st;
  logic        w_is_ld;
  logic        w_ret;
  logic [2:0]  w_len;

  assign w_base  = (r_insn[7:0] == 8'hDD) ? r_ix : r_iy;
  assign w_ea    = w_base + {{8{r_insn[23]}}, r_insn[23:16]};
  assign w_is_st = (r_insn[15:8] == 8'h36);
  // LD r,(IX/IY+d): 01 rrr 110 with rrr != 110 (0x76 is HALT)
  assign w_is_ld = (mem_rdata[7:6] == 2'b01) && (mem_rdata[2:0] == 3'b110) &&
                   (mem_rdata[5:3] != 3'b110);
  assign w_ret   = (r_state == RETIRE);
  assign w_len   = w_is_st ? 3'd4 : 3'd3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_req  = 1'b0;
    w_addr = '0;
    case (r_state)
      IDLE:   if (start) w_next = F_PFX;
      F_PFX: begin
        w_req  = 1'b1;
        w_addr = r_ip;
        if (mem_ack) begin
          if (mem_rdata == 8'hDD || mem_rdata == 8'hFD) w_next = F_OP;
          else begin w_next = IDLE; w_err = 1'b1; end
        end
      end
      F_OP: begin
        w_req  = 1'b1;
        w_addr = r_ip + 16'd1;
        if (mem_ack) begin
          if (mem_rdata == 8'h36 || w_is_ld) w_next = F_D;
          else begin w_next = IDLE; w_err = 1'b1; end
        end
      end
      F_D: begin
        w_req  = 1'b1;
        w_addr = r_ip + 16'd2;
        if (mem_ack) w_next = w_is_st ? F_N : MEM_RD;
      end
      F_N: begin
        w_req  = 1'b1;
        w_addr = r_ip + 16'd3;
        if (mem_ack) w_next = MEM_WR;
      end
      MEM_WR, MEM_RD: begin
        w_req  = 1'b1;
        w_addr = w_ea;
        if (mem_ack) w_next = RETIRE;
      end
      RETIRE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_req && !mem_ack && (r_wait == ACK_TIMEOUT)) begin
      w_next = IDLE;
      w_err  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ip    <= '0;
      r_ix    <= '0;
      r_iy    <= '0;
      r_insn  <= '0;
      r_rdata <= '0;
      r_wait  <= '0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_err;
      if (r_state == IDLE) begin
        r_wait <= '0;
        if (start) begin
          r_ip    <= ip_in;
          r_ix    <= ix_in;
          r_iy    <= iy_in;
          r_insn  <= '0;
          r_rdata <= '0;
        end
      end else if (w_req) begin
        if (mem_ack) begin
          r_wait <= '0;
          case (r_state)
            F_PFX:   r_insn[7:0]   <= mem_rdata;
            F_OP:    r_insn[15:8]  <= mem_rdata;
            F_D:     r_insn[23:16] <= mem_rdata;
            F_N:     r_insn[31:24] <= mem_rdata;
            MEM_RD:  r_rdata       <= mem_rdata;
            default: ;
          endcase
        end else begin
          r_wait <= r_wait + 32'd1;
        end
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign mem_req   = w_req;
  assign mem_addr  = w_addr;
  assign mem_wr    = (r_state == MEM_WR);
  assign mem_wdata = (r_state == MEM_WR) ? r_insn[31:24] : 8'h00;
  assign error     = r_error;

  assign reg_we    = w_ret && !w_is_st;
  assign reg_sel   = (w_ret && !w_is_st) ? r_insn[13:11] : 3'd0;
  assign reg_wdata = (w_ret && !w_is_st) ? r_rdata : 8'h00;

  assign z80fi_valid      = w_ret;
  assign z80fi_insn       = w_ret ? r_insn : '0;
  assign z80fi_insn_len   = w_ret ? w_len : 3'd0;
  assign z80fi_reg_ip_in  = w_ret ? r_ip : '0;
  assign z80fi_reg_ip_out = w_ret ? (r_ip + {13'd0, w_len}) : '0;
  assign z80fi_reg_ix_in  = w_ret ? r_ix : '0;
  assign z80fi_reg_iy_in  = w_ret ? r_iy : '0;
  assign z80fi_mem_wr     = w_ret && w_is_st;
  assign z80fi_mem_rd     = w_ret && !w_is_st;
  assign z80fi_mem_waddr  = (w_ret && w_is_st) ? w_ea : '0;
  assign z80fi_mem_wdata  = (w_ret && w_is_st) ? r_insn[31:24] : 8'h00;
  assign z80fi_mem_raddr  = (w_ret && !w_is_st) ? w_ea : '0;
  assign z80fi_mem_rdata  = (w_ret && !w_is_st) ? r_rdata : 8'h00;

endmodule

// File: tb/tb_z80_idx_exec.sv
module tb_z80_idx_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] ip_in, ix_in, iy_in;
  logic        busy, mem_req, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        reg_we;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_wdata;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_ix_in, z80fi_reg_iy_in;
  logic        z80fi_mem_wr, z80fi_mem_rd;
  logic [15:0] z80fi_mem_waddr, z80fi_mem_raddr;
  logic [7:0]  z80fi_mem_wdata, z80fi_mem_rdata;
  logic        error;

  z80_idx_exec #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .ip_in(ip_in), .ix_in(ix_in), .iy_in(iy_in),
    .busy(busy), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_ip_out(z80fi_reg_ip_out),
    .z80fi_reg_ix_in(z80fi_reg_ix_in), .z80fi_reg_iy_in(z80fi_reg_iy_in),
    .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_rd(z80fi_mem_rd),
    .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_raddr(z80fi_mem_raddr),
    .z80fi_mem_wdata(z80fi_mem_wdata), .z80fi_mem_rdata(z80fi_mem_rdata),
    .error(error)
  );

  always #5 clk = ~clk;

  // Every DUT output, used for the all-zero checks.
  logic [189:0] all_out;
  assign all_out = {busy, mem_req, mem_wr, mem_addr, mem_wdata, reg_we, reg_sel,
                    reg_wdata, z80fi_valid, z80fi_insn, z80fi_insn_len,
                    z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_ix_in,
                    z80fi_reg_iy_in, z80fi_mem_wr, z80fi_mem_rd, z80fi_mem_waddr,
                    z80fi_mem_raddr, z80fi_mem_wdata, z80fi_mem_rdata, error};

  int checks = 0;
  int errors = 0;

  // Bus memory model
  logic [7:0]  mem [0:65535];
  logic [24:0] acc_q [$];
  logic [24:0] held;
  logic        pending;
  int          wcnt;
  int          ack_delay = 0;
  logic        hold_wr = 1'b0;
  int          stab_err = 0;

  // Retirement monitor
  int          valid_cnt = 0;
  int          err_cyc = 0;
  int          we_cnt = 0;
  logic [31:0] s_insn;
  logic [2:0]  s_len, s_sel;
  logic [15:0] s_ipin, s_ipout, s_ix, s_iy, s_waddr, s_raddr;
  logic        s_mwr, s_mrd, s_we;
  logic [7:0]  s_wdata, s_rdata, s_wd;

  initial begin
    mem_ack = 1'b0; mem_rdata = 8'h00; pending = 1'b0; wcnt = 0; held = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (pending && ({mem_wr, mem_addr, mem_wdata} !== held)) stab_err++;
        if (!pending) begin
          held = {mem_wr, mem_addr, mem_wdata};
          wcnt = 0;
        end
        if (wcnt >= ack_delay && !(mem_wr && hold_wr)) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_wr) mem[mem_addr] = mem_wdata;
          acc_q.push_back({mem_wr, mem_addr, mem_wdata});
          pending = 1'b0;
        end else begin
          wcnt++;
          pending = 1'b1;
        end
      end else begin
        pending = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (z80fi_valid) begin
        valid_cnt++;
        s_insn = z80fi_insn; s_len = z80fi_insn_len;
        s_ipin = z80fi_reg_ip_in; s_ipout = z80fi_reg_ip_out;
        s_ix = z80fi_reg_ix_in; s_iy = z80fi_reg_iy_in;
        s_mwr = z80fi_mem_wr; s_mrd = z80fi_mem_rd;
        s_waddr = z80fi_mem_waddr; s_raddr = z80fi_mem_raddr;
        s_wdata = z80fi_mem_wdata; s_rdata = z80fi_mem_rdata;
        s_we = reg_we; s_sel = reg_sel; s_wd = reg_wdata;
      end
      if (error) err_cyc++;
      if (reg_we) we_cnt++;
    end
  end

  task automatic clear_obs();
    valid_cnt = 0; err_cyc = 0; we_cnt = 0; stab_err = 0;
    acc_q.delete();
    s_insn = '0; s_len = '0; s_ipin = '0; s_ipout = '0; s_ix = '0; s_iy = '0;
    s_mwr = 1'b0; s_mrd = 1'b0; s_waddr = '0; s_raddr = '0; s_wdata = '0;
    s_rdata = '0; s_we = 1'b0; s_sel = '0; s_wd = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0 within 200 cycles", busy);
    end
  endtask

  task automatic run_insn(input logic [15:0] ip, input logic [15:0] ix, input logic [15:0] iy);
    clear_obs();
    @(negedge clk);
    ip_in = ip; ix_in = ix; iy_in = iy; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; ip_in = '0; ix_in = '0; iy_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_out); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL idle_outputs: got %h required 0", all_out); end
  endtask

  task automatic test_store();
    logic [24:0] exp_acc [5];
    exp_acc = '{{1'b0, 16'h1000, 8'h00}, {1'b0, 16'h1001, 8'h00}, {1'b0, 16'h1002, 8'h00},
                {1'b0, 16'h1003, 8'h00}, {1'b1, 16'h2005, 8'hAA}};
    mem[16'h1000] = 8'hDD; mem[16'h1001] = 8'h36; mem[16'h1002] = 8'h05; mem[16'h1003] = 8'hAA;
    mem[16'h2005] = 8'h00;
    run_insn(16'h1000, 16'h2000, 16'h0000);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL st_valid_cnt: got %0d required 1", valid_cnt); end
    checks++; if (err_cyc !== 0) begin errors++; $display("FAIL st_error: got %0d required 0", err_cyc); end
    checks++; if (s_insn !== 32'hAA0536DD) begin errors++; $display("FAIL st_insn: got %h required AA0536DD", s_insn); end
    checks++; if (s_len !== 3'd4) begin errors++; $display("FAIL st_len: got %0d required 4", s_len); end
    checks++; if ({s_ipin, s_ipout} !== {16'h1000, 16'h1004}) begin errors++; $display("FAIL st_ip: got %h/%h required 1000/1004", s_ipin, s_ipout); end
    checks++; if ({s_ix, s_iy} !== {16'h2000, 16'h0000}) begin errors++; $display("FAIL st_idx: got %h/%h required 2000/0000", s_ix, s_iy); end
    checks++; if ({s_mwr, s_waddr, s_wdata} !== {1'b1, 16'h2005, 8'hAA}) begin errors++; $display("FAIL st_fi_wr: got %b %h %h required 1 2005 AA", s_mwr, s_waddr, s_wdata); end
    checks++; if ({s_mrd, s_raddr, s_rdata} !== 25'd0) begin errors++; $display("FAIL st_fi_rd: got %b %h %h required 0 0 0", s_mrd, s_raddr, s_rdata); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL st_reg_we: got %0d required 0", we_cnt); end
    checks++; if (mem[16'h2005] !== 8'hAA) begin errors++; $display("FAIL st_mem: got %h required AA", mem[16'h2005]); end
    checks++; if (acc_q.size() !== 5) begin errors++; $display("FAIL st_acc_count: got %0d required 5", acc_q.size()); end
    for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] !== exp_acc[i]) begin errors++; $display("FAIL st_acc%0d: got %h required %h", i, acc_q[i], exp_acc[i]); end
    end
  endtask

  task automatic test_load();
    logic [24:0] exp_acc [4];
    exp_acc = '{{1'b0, 16'h3000, 8'h00}, {1'b0, 16'h3001, 8'h00}, {1'b0, 16'h3002, 8'h00},
                {1'b0, 16'hFF85, 8'h00}};
    mem[16'h3000] = 8'hFD; mem[16'h3001] = 8'h7E; mem[16'h3002] = 8'h80; mem[16'hFF85] = 8'h3C;
    run_insn(16'h3000, 16'h1234, 16'h0005);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL ld_valid_cnt: got %0d required 1", valid_cnt); end
    checks++; if (s_insn !== 32'h00807EFD) begin errors++; $display("FAIL ld_insn: got %h required 00807EFD", s_insn); end
    checks++; if ({s_len, s_ipout} !== {3'd3, 16'h3003}) begin errors++; $display("FAIL ld_len_ip: got %0d/%h required 3/3003", s_len, s_ipout); end
    checks++; if ({s_we, s_sel, s_wd} !== {1'b1, 3'd7, 8'h3C}) begin errors++; $display("FAIL ld_reg: got %b %0d %h required 1 7 3C", s_we, s_sel, s_wd); end
    checks++; if ({s_mrd, s_raddr, s_rdata} !== {1'b1, 16'hFF85, 8'h3C}) begin errors++; $display("FAIL ld_fi_rd: got %b %h %h required 1 FF85 3C", s_mrd, s_raddr, s_rdata); end
    checks++; if ({s_mwr, s_waddr, s_wdata} !== 25'd0) begin errors++; $display("FAIL ld_fi_wr: got %b %h %h required 0 0 0", s_mwr, s_waddr, s_wdata); end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL ld_we_cnt: got %0d required 1", we_cnt); end
    checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL ld_acc_count: got %0d required 4", acc_q.size()); end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] !== exp_acc[i]) begin errors++; $display("FAIL ld_acc%0d: got %h required %h", i, acc_q[i], exp_acc[i]); end
    end
    // LD B,(IX+0x20) with IX=0xFFF0: EA wraps upward to 0x0010
    mem[16'h4000] = 8'hDD; mem[16'h4001] = 8'h46; mem[16'h4002] = 8'h20; mem[16'h0010] = 8'h5A;
    run_insn(16'h4000, 16'hFFF0, 16'h0000);
    checks++; if ({s_raddr, s_sel, s_wd} !== {16'h0010, 3'd0, 8'h5A}) begin errors++; $display("FAIL ld_wrap: got %h %0d %h required 0010 0 5A", s_raddr, s_sel, s_wd); end
  endtask

  task automatic test_wrap();
    logic [24:0] exp_acc [5];
    exp_acc = '{{1'b0, 16'hFFFE, 8'h00}, {1'b0, 16'hFFFF, 8'h00}, {1'b0, 16'h0000, 8'h00},
                {1'b0, 16'h0001, 8'h00}, {1'b1, 16'hFFFF, 8'h11}};
    mem[16'hFFFE] = 8'hDD; mem[16'hFFFF] = 8'h36; mem[16'h0000] = 8'hFF; mem[16'h0001] = 8'h11;
    run_insn(16'hFFFE, 16'h0000, 16'h0000);
    checks++; if (s_insn !== 32'h11FF36DD) begin errors++; $display("FAIL wr_insn: got %h required 11FF36DD", s_insn); end
    checks++; if (s_ipout !== 16'h0002) begin errors++; $display("FAIL wr_ip_out: got %h required 0002", s_ipout); end
    checks++; if (acc_q.size() !== 5) begin errors++; $display("FAIL wr_acc_count: got %0d required 5", acc_q.size()); end
    for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] !== exp_acc[i]) begin errors++; $display("FAIL wr_acc%0d: got %h required %h", i, acc_q[i], exp_acc[i]); end
    end
  endtask

  task automatic test_illegal();
    mem[16'h5000] = 8'hDD; mem[16'h5001] = 8'h76;
    run_insn(16'h5000, 16'h0000, 16'h0000);
    checks++; if ({valid_cnt, err_cyc} !== {32'd0, 32'd1}) begin errors++; $display("FAIL ill_op: valid=%0d err_cycles=%0d required 0/1", valid_cnt, err_cyc); end
    checks++; if (acc_q.size() !== 2) begin errors++; $display("FAIL ill_op_acc: got %0d required 2", acc_q.size()); end
    mem[16'h5100] = 8'hED; mem[16'h5101] = 8'h36;
    run_insn(16'h5100, 16'h0000, 16'h0000);
    checks++; if ({valid_cnt, err_cyc} !== {32'd0, 32'd1}) begin errors++; $display("FAIL ill_pfx: valid=%0d err_cycles=%0d required 0/1", valid_cnt, err_cyc); end
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL ill_pfx_acc: got %0d required 1", acc_q.size()); end
  endtask

  task automatic test_timeout();
    ack_delay = 16;
    run_insn(16'h1000, 16'h2000, 16'h0000);
    checks++; if ({valid_cnt, err_cyc} !== {32'd0, 32'd1}) begin errors++; $display("FAIL to_err: valid=%0d err_cycles=%0d required 0/1", valid_cnt, err_cyc); end
    checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL to_idle: req/busy=%b required 00", {mem_req, busy}); end
    checks++; if (acc_q.size() !== 0) begin errors++; $display("FAIL to_acc: got %0d required 0", acc_q.size()); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL to_stable: got %0d required 0", stab_err); end
    ack_delay = 10;
    mem[16'h2005] = 8'h00;
    run_insn(16'h1000, 16'h2000, 16'h0000);
    checks++; if ({valid_cnt, err_cyc} !== {32'd1, 32'd0}) begin errors++; $display("FAIL slow_ok: valid=%0d err_cycles=%0d required 1/0", valid_cnt, err_cyc); end
    checks++; if ({s_insn, mem[16'h2005]} !== {32'hAA0536DD, 8'hAA}) begin errors++; $display("FAIL slow_data: got %h %h required AA0536DD AA", s_insn, mem[16'h2005]); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL slow_stable: got %0d required 0", stab_err); end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    mem[16'h2005] = 8'h00;
    hold_wr = 1'b1;
    clear_obs();
    @(negedge clk);
    ip_in = 16'h1000; ix_in = 16'h2000; iy_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_wr) break;
      @(negedge clk);
    end
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rm_reach_wr: mem_wr=%b required 1", mem_wr); end
    ip_in = 16'h3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, mem_wr, mem_addr} !== {1'b1, 1'b1, 16'h2005}) begin errors++; $display("FAIL rm_busy_start: got %b %b %h required 1 1 2005", busy, mem_wr, mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL rm_async: got %h required 0", all_out); end
    @(negedge clk);
    reset_n = 1'b1;
    hold_wr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (all_out !== '0) begin errors++; $display("FAIL rm_after: got %h required 0", all_out); end
    checks++; if ({valid_cnt, err_cyc, 24'd0, mem[16'h2005]} !== 72'd0) begin errors++; $display("FAIL rm_no_retire: valid=%0d err=%0d mem=%h required 0 0 00", valid_cnt, err_cyc, mem[16'h2005]); end
  endtask

  task automatic test_back_to_back();
    mem[16'h6000] = 8'hFD; mem[16'h6001] = 8'h46; mem[16'h6002] = 8'h01; mem[16'h7001] = 8'h99;
    mem[16'h6100] = 8'hDD; mem[16'h6101] = 8'h36; mem[16'h6102] = 8'h00; mem[16'h6103] = 8'h42;
    mem[16'h7100] = 8'h00;
    clear_obs();
    @(negedge clk);
    ip_in = 16'h6000; ix_in = 16'h0000; iy_in = 16'h7000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (z80fi_valid) break;
      @(negedge clk);
    end
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_retire: got %b required 1", z80fi_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_retire: busy=%b required 0", busy); end
    ip_in = 16'h6100; ix_in = 16'h7100; iy_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, mem_req, mem_addr} !== {1'b1, 1'b1, 16'h6100}) begin errors++; $display("FAIL b2b_accept: got %b %b %h required 1 1 6100", busy, mem_req, mem_addr); end
    wait_idle();
    checks++; if ({valid_cnt, we_cnt} !== {32'd2, 32'd1}) begin errors++; $display("FAIL b2b_counts: valid=%0d we=%0d required 2/1", valid_cnt, we_cnt); end
    checks++; if (mem[16'h7100] !== 8'h42) begin errors++; $display("FAIL b2b_mem: got %h required 42", mem[16'h7100]); end
  endtask

  initial begin
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 8'h00;
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
